// File: rtl/gray_to_binary_decoder.sv
// Gray-to-binary decoder, MSB-first at one bit per clock, with an optional adjacency check against the previously accepted code.
// out_valid rises WIDTH-1 edges after accept and holds until out_ready; in_ready is high only while idle, so no word is ever queued.
module gray_to_binary_decoder #(
  parameter int WIDTH     = 4,
  parameter bit CHECK_ADJ = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] gray,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] binary,
  output logic             adj_err
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_HOLD} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] w_work_step;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_prev;
  logic             r_prev_vld;
  logic             r_err;
  logic [WIDTH-1:0] r_binary;
  logic             r_adj_err;
  logic             w_accept;
  logic             w_adj_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (in_valid) w_state_nxt = (WIDTH == 1) ? S_HOLD : S_DECODE;
      S_DECODE: if (r_idx == '0) w_state_nxt = S_HOLD;
      S_HOLD:   if (out_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_HOLD);
  end

  assign w_accept  = in_valid && in_ready;
  assign w_adj_err = CHECK_ADJ && r_prev_vld && ($countones(gray ^ r_prev) != 1);

  // r_work starts as the Gray word; each step overwrites bit idx in place,
  // so bits below idx still hold their Gray value when their turn comes.
  always_comb begin
    w_work_step = r_work;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (IDXW'(i) == r_idx) w_work_step[i] = r_work[i+1] ^ r_work[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_work     <= '0;
      r_idx      <= '0;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      r_err      <= 1'b0;
      r_binary   <= '0;
      r_adj_err  <= 1'b0;
    end else if (w_accept) begin
      r_work     <= gray;
      r_idx      <= IDXW'(WIDTH - 2);
      r_err      <= w_adj_err;
      r_prev     <= gray;
      r_prev_vld <= 1'b1;
      if (WIDTH == 1) begin
        r_binary  <= gray;
        r_adj_err <= w_adj_err;
      end
    end else if (r_state == S_DECODE) begin
      r_work <= w_work_step;
      r_idx  <= r_idx - IDXW'(1);
      if (r_idx == '0) begin
        r_binary  <= w_work_step;
        r_adj_err <= r_err;
      end
    end
  end

  assign binary  = r_binary;
  assign adj_err = r_adj_err;

endmodule

// File: doc/gray_to_binary_decoder.md
Name: gray_to_binary_decoder

Overview:
Sequential Gray-to-binary decoder. It is the inverse of the team's binary-to-Gray converter and sits on the receive side of Gray-coded buses, such as async FIFO pointers and position encoders. It accepts one Gray word per valid/ready handshake and decodes it MSB-first at one bit per clock. It presents the binary result under a valid/ready handshake and optionally flags input codes that are not adjacent to the previous accepted code.

Parameters:
WIDTH, 4, Gray/binary word width; legal range 1..32.
CHECK_ADJ, 1, 1 = enable the adjacency check on adj_err; 0 = adj_err tied low.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  gray is valid.
in_ready  output  1  decoder can accept a word.
gray  input  WIDTH  Gray-coded input word.
out_valid  output  1  binary/adj_err are valid.
out_ready  input  1  downstream accepts the result.
binary  output  WIDTH  decoded binary word.
adj_err  output  1  current code differs from the previous accepted code in a number of bits other than exactly 1.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE; out_valid=0; binary=0; adj_err=0.
  - Work registers cleared; prev-valid flag cleared.
  - in_ready is combinational from state, so it reads 1 during reset.
- States: IDLE, DECODE, HOLD.
- in_ready = (state==IDLE). Words presented outside IDLE are ignored, never queued.
- Accept: the edge where in_valid && in_ready.
  - Latch gray into a work register.
  - Set work_bin[WIDTH-1] = gray[WIDTH-1].
  - Set idx = WIDTH-2.
  - If CHECK_ADJ and prev-valid: latch err = (popcount(gray ^ prev) != 1). Otherwise err = 0.
  - prev <= gray; prev-valid <= 1.
  - Next state: DECODE, or HOLD directly if WIDTH==1.
- DECODE, one bit per edge:
  - work_bin[idx] = work_bin[idx+1] ^ gray_reg[idx].
  - idx decrements.
  - On the edge computing idx==0: binary <= full result, adj_err <= err, out_valid <= 1, state <= HOLD.
- Latency: out_valid rises WIDTH-1 edges after the accept edge (3 for WIDTH=4; 0 extra for WIDTH=1, where it rises on the accept edge).
- HOLD:
  - binary, adj_err and out_valid stay stable until out_ready is sampled high.
  - On that edge: out_valid <= 0, state <= IDLE.
  - The next accept is possible on the following edge at the earliest. Throughput is 1 word per WIDTH+1 cycles with out_ready tied high.
- binary and adj_err keep their last values outside HOLD; they are meaningful only while out_valid=1.
- Adjacency rule:
  - The first word after reset never flags.
  - A repeated identical code flags, since popcount is 0.
  - Wrap-around from 1000 to 0000 (WIDTH=4) is adjacent and does not flag.
- out_ready while out_valid=0 has no effect. in_valid held high through DECODE/HOLD does not cause a second accept until IDLE.
- Reset mid-DECODE or mid-HOLD:
  - The in-flight word is dropped and out_valid drops immediately.
  - Adjacency history is lost; the next word is treated as first.

Test Plan:
- After reset (WIDTH=4): outputs 0, in_ready=1. Accept gray=0000 -> out_valid 3 edges later, binary=0000, adj_err=0.
- Single decodes, each exercising the full XOR chain: gray=1000 -> binary=1111; gray=0100 -> 0111; gray=1101 -> 1001.
- Adjacency, stream 0000, 0001, 0011, 0010, then 1000, then 1000 again:
  - 0000, 0001, 0011, 0010 -> binaries 0, 1, 2, 3 with adj_err=0.
  - 1000 -> binary=1111, adj_err=1 (2 bits changed).
  - Repeat 1000 -> adj_err=1.
  - Wrap 1000 -> 0000 in a fresh stream -> adj_err=0.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD with binary=0101 -> binary, adj_err, out_valid stable; in_ready=0; new in_valid words ignored. Release out_ready -> IDLE next edge, in_ready=1.
- Reset mid-operation: assert rst one cycle after accepting 1111 -> out_valid=0 and binary=0 with no clock edge. Next word 0110 decodes to 0100 with adj_err=0 (history cleared).
- CHECK_ADJ=0 and WIDTH=1:
  - CHECK_ADJ=0, stream 0000 -> 1111 -> adj_err stays 0.
  - WIDTH=1: gray=1 -> binary=1, out_valid on the accept edge.
